fp32_accumulator: RTL and testbench
===================================

# fp32_accumulator

Sequential FP32 accumulator sitting directly downstream of the combinational FP32 multiplier in the vip_core datapath. It consumes a stream of `len` products over a valid/ready handshake and sums them into one FP32 result: the dot product for one convolution/FC output. It presents that result on a registered valid/ready output port. Its arithmetic conventions match the multiplier: truncation, with no rounding, infinity, NaN or denormal support.

## Interface
- `LEN_W`, default 16: width of the term-count input; the maximum terms per job is 2^LEN_W − 1.
- `clk`  in  1  the single clock for the block; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `len`  in  LEN_W  number of terms in the job; captured on an accepted `start`.
- `in_valid`  in  1  `in_data` holds a product.
- `in_ready`  out  1  accumulator accepts a term this cycle.
- `in_data`  in  32  FP32 product from the multiplier.
- `out_valid`  out  1  `out_data` holds the finished sum.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  32  FP32 sum, registered.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, ACC and DONE.
  - IDLE: on `start`, clear `acc` to 32'h0 and load `cnt` = `len`. If `len` == 0, go to DONE; otherwise go to ACC.
  - ACC: `in_ready` = 1. On each beat where `in_valid && in_ready`: `acc` ← fpadd(`acc`, `in_data`) and `cnt` ← `cnt` − 1. When the beat with `cnt` == 1 is accepted, go to DONE.
  - DONE: `out_valid` = 1 and `out_data` = `acc`. On `out_ready`, go to IDLE.
- `start` outside IDLE is ignored.
- `in_valid` outside ACC is ignored, and no term is consumed.
- fpadd rules:
  - Any operand with exponent field 0 is treated as zero; the other operand passes through unchanged.
  - Mantissas are 24 bits including the hidden 1.
  - The smaller-magnitude operand is right-shifted by the exponent difference, and shifted-out bits are discarded. A difference ≥ 25 means that operand contributes nothing.
  - Same signs add; differing signs subtract the smaller from the larger. The result takes the sign of the larger magnitude.
  - Normalisation:
    - On carry-out: shift right 1 and increment the exponent.
    - Otherwise: left-shift by the leading-zero count and subtract that count from the exponent.
  - An exact cancellation gives 32'h00000000.
  - A normalised exponent ≤ 0 flushes to 32'h00000000.
  - A normalised exponent ≥ 255 saturates to {sign, 8'hFE, 23'h7FFFFF}.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: `in_ready` 0, `out_valid` 0, `out_data` 32'h0, `busy` 0.
  - Internal registers: `acc` 0, `cnt` 0.
- `start` accepted in cycle t gives `busy` = 1 and `in_ready` = 1 in cycle t+1. With `len` == 0 it instead gives `out_valid` = 1 in cycle t+1.
- Throughput: one term per cycle while `in_valid` stays high; fpadd is single-cycle combinational into `acc`.
- The last term accepted in cycle t gives `out_valid` = 1 in cycle t+1, with `in_ready` already 0.
- `out_valid` stays high and `out_data` stays stable until `out_ready`. The handshake cycle returns to IDLE, so `out_valid` = 0 on the next cycle.
- `rst` asserted in any state returns the block to reset values on the next edge. Partial sums and pending results are discarded.

## Configuration
- `FP_ACC_RELU_EN`
  - Defined: a result whose sign bit is 1 is replaced by 32'h00000000 when it is written to `out_data`. This is the fused ReLU.
  - Undefined: `out_data` is the raw sum, negative values included.

## Structure
- Package `fp_acc_pkg` holds:
  - The state enum {IDLE, ACC, DONE}.
  - FP32 field widths: EXP_W = 8, MAN_W = 23.
  - EXP_BIAS = 127 and FP_ZERO = 32'h0.
  - The saturation constant.
- One sub-module, `fp32_adder`: purely combinational, implementing the fpadd rules.
- The top level holds the FSM, `cnt`, `acc` and the output register.

## Test plan
- `len` = 3; terms 3F800000, 40000000, 40400000 sent back to back → `out_valid` in the cycle after the third accept, `out_data` = 40C00000 (6.0).
- `len` = 2; terms 40200000, C0200000 → `out_data` = 00000000 (exact cancellation).
- `len` = 2; terms 4E800000, 3F800000 → `out_data` = 4E800000 (1.0 aligned out).
- `len` = 0 → `out_valid` one cycle after `start`, `out_data` = 00000000. Separately: hold `out_ready` low for 5 cycles → `out_valid` and `out_data` stay stable, and `start` pulses during DONE are ignored.
- `len` = 4; assert `rst` after 2 accepted terms → next cycle `busy` = 0, `in_ready` = 0, `out_valid` = 0. A new job with `len` = 1, term 3F800000 → `out_data` = 3F800000.
- `len` = 2; terms BF800000, C0000000 → `out_data` = C0400000 without `FP_ACC_RELU_EN`, and 00000000 with it.

Source files
------------

// File: rtl/fp_acc_pkg.sv
// ---------------------------------------------------------------------------
// fp_acc_pkg
// Shared definitions for the FP32 accumulator slice:
//   - state_e        : accumulator FSM states (IDLE, ACC, DONE)
//   - EXP_W / MAN_W  : FP32 exponent and stored-mantissa widths
//   - EXP_BIAS       : FP32 exponent bias
//   - FP_ZERO        : canonical positive zero
//   - FP_SAT_MAG     : magnitude used when a sum overflows (max finite value)
//   - lzc24()        : leading-zero count of a 24-bit mantissa
// ---------------------------------------------------------------------------
package fp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Largest finite magnitude: exponent FE, mantissa all ones. There is no
  // infinity in this datapath, so overflow clamps here.
  localparam logic [30:0] FP_SAT_MAG = {8'hFE, 23'h7F_FFFF};

  // Number of zeros above the most significant set bit. Returns 24 for an
  // all-zero input; callers treat that case separately.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_adder.sv
// ---------------------------------------------------------------------------
// fp32_adder
// Purely combinational FP32 adder using the datapath's reduced arithmetic:
// truncation only, no rounding, no infinity/NaN/denormal handling.
//   - An operand with exponent field 0 is zero; the other passes through.
//   - The smaller magnitude is right-shifted by the exponent difference and
//     the shifted-out bits are dropped (difference >= 25 contributes nothing).
//   - Result sign follows the larger magnitude.
//   - Exact cancellation and exponent underflow give +0; exponent overflow
//     clamps to {sign, FE, 7FFFFF}.
// Ports:
//   i_a, i_b : FP32 operands
//   o_sum    : FP32 result
// ---------------------------------------------------------------------------
module fp32_adder
  import fp_acc_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);

  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_a_big;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic        w_sign;
  logic        w_sub;
  logic [7:0]  w_e_big;
  logic [7:0]  w_e_small;
  logic [7:0]  w_diff;
  logic [23:0] w_m_big;
  logic [23:0] w_m_shift;
  logic [24:0] w_raw;
  logic [4:0]  w_lz;
  logic [22:0] w_norm;
  logic [9:0]  w_exp;
  logic [22:0] w_man;

  always_comb begin
    w_a_zero = (i_a[MAN_W+EXP_W-1:MAN_W] == 8'd0);
    w_b_zero = (i_b[MAN_W+EXP_W-1:MAN_W] == 8'd0);

    // Comparing {exponent, mantissa} as one unsigned field orders magnitudes.
    w_a_big  = (i_a[30:0] >= i_b[30:0]);
    w_big    = w_a_big ? i_a : i_b;
    w_small  = w_a_big ? i_b : i_a;
    w_sign   = w_big[31];
    w_sub    = w_big[31] ^ w_small[31];

    w_e_big   = w_big[30:23];
    w_e_small = w_small[30:23];
    w_diff    = w_e_big - w_e_small;

    w_m_big   = {1'b1, w_big[MAN_W-1:0]};
    w_m_shift = (w_diff >= 8'd25) ? 24'd0 : ({1'b1, w_small[MAN_W-1:0]} >> w_diff);

    // Bit 24 is the carry-out of an effective addition. For subtraction the
    // larger magnitude is always the minuend, so no borrow is possible.
    if (w_sub) w_raw = {1'b0, w_m_big} - {1'b0, w_m_shift};
    else       w_raw = {1'b0, w_m_big} + {1'b0, w_m_shift};

    w_lz   = lzc24(w_raw[23:0]);
    // Only the bits below the hidden 1 survive after the left shift.
    w_norm = w_raw[22:0] << w_lz;

    // Exponent is carried at 10 bits so underflow shows up as bit 9.
    if (w_raw[24]) begin
      w_exp = {2'b00, w_e_big} + 10'd1;
      w_man = w_raw[23:1];
    end else begin
      w_exp = {2'b00, w_e_big} - {5'd0, w_lz};
      w_man = w_norm;
    end

    if (w_a_zero) begin
      o_sum = i_b;
    end else if (w_b_zero) begin
      o_sum = i_a;
    end else if (w_raw == 25'd0) begin
      o_sum = FP_ZERO;
    end else if (w_exp[9] || (w_exp == 10'd0)) begin
      o_sum = FP_ZERO;
    end else if (w_exp >= 10'd255) begin
      o_sum = {w_sign, FP_SAT_MAG};
    end else begin
      o_sum = {w_sign, w_exp[7:0], w_man};
    end
  end

endmodule

// File: rtl/fp32_accumulator.sv
// ---------------------------------------------------------------------------
// fp32_accumulator
// Sums a job of i_len FP32 products into one FP32 result (one dot product).
// Optional feature macro: FP_ACC_RELU_EN -- when defined, a negative result
// is replaced by +0 as it is written to o_out_data (fused ReLU).
//
// Handshakes (both ports): a beat transfers on a rising edge where valid and
// ready are both high. A producer holding valid keeps its data stable until
// the transfer; ready may be asserted independently of valid.
//
// Ports:
//   i_clk       : clock, all state on rising edge
//   i_rst       : synchronous active-high reset
//   i_start     : job start pulse, sampled only in IDLE
//   i_len       : term count, captured with an accepted start
//   i_in_valid  : i_in_data holds a product
//   o_in_ready  : a term is accepted this cycle (high only in ACC)
//   i_in_data   : FP32 product
//   o_out_valid : o_out_data holds the finished sum (high only in DONE)
//   i_out_ready : downstream takes the result
//   o_out_data  : registered FP32 sum
//   o_busy      : high in every state except IDLE
//   o_state     : current FSM state, for observation
// ---------------------------------------------------------------------------
module fp32_accumulator
  import fp_acc_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_data,
  output logic             o_busy,
  output logic [1:0]       o_state
);

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_next;
  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_out_data;

  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_sum;
  logic [31:0]      w_result;

  fp32_adder u_adder (
    .i_a   (r_acc),
    .i_b   (i_in_data),
    .o_sum (w_sum)
  );

  assign w_accept = (r_state == ACC) && i_in_valid;
  assign w_last   = w_accept && (r_cnt == CNT_ONE);

`ifdef FP_ACC_RELU_EN
  assign w_result = w_sum[31] ? FP_ZERO : w_sum;
`else
  assign w_result = w_sum;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = (i_len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        if (i_out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_acc      <= FP_ZERO;
      r_cnt      <= '0;
      r_out_data <= FP_ZERO;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_acc <= FP_ZERO;
            r_cnt <= i_len;
            // An empty job finishes immediately with a zero sum.
            if (i_len == '0) r_out_data <= FP_ZERO;
          end
        end
        ACC: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - CNT_ONE;
            // Capture the final sum straight from the adder so the result is
            // valid the cycle after the last term.
            if (w_last) r_out_data <= w_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == ACC);
  assign o_out_valid = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_out_data  = r_out_data;
  assign o_state     = r_state;

endmodule

// File: tb/tb_fp32_accumulator.sv
module tb_fp32_accumulator;

  localparam int LEN_W = 16;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;
  logic [1:0]       state;

  always #5 clk = ~clk;

  fp32_accumulator #(.LEN_W(LEN_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_len       (len),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_busy      (busy),
    .o_state     (state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Exact FP32 encoding of a small integer (|v| < 2^24).
  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] m;
    logic [31:0] r;
    logic        s;
    int          p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    r = m << (23 - p);
    return {s, 8'(127 + p), r[22:0]};
  endfunction

  function automatic logic [31:0] relu_exp(input logic [31:0] v);
`ifdef FP_ACC_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send_term(input logic [31:0] d, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid and returns the presented data.
  task automatic collect(output logic [31:0] d, output bit timed_out);
    timed_out = 1'b1;
    d = 32'h0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) begin
        timed_out = 1'b0;
        d = out_data;
        break;
      end
      tick();
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sum_basic();
    logic [31:0] e;
    exp_q.push_back(relu_exp(32'h40C0_0000));
    do_start(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready got %b exp 1", in_ready); end
    send_term(32'h3F80_0000, 0);
    send_term(32'h4000_0000, 0);
    send_term(32'h4040_0000, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL last_out_valid got %b exp 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL last_in_ready got %b exp 0", in_ready); end
    e = exp_q.pop_front();
    checks++; if (out_data !== e) begin errors++; $display("FAIL sum_6 got %h exp %h", out_data, e); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_handshake_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_pair(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expected);
    logic [31:0] d, e;
    bit to;
    exp_q.push_back(relu_exp(expected));
    do_start(2);
    send_term(a, 0);
    send_term(b, 1);
    collect(d, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL %s timeout waiting out_valid", name); end
    else if (d !== e) begin errors++; $display("FAIL %s got %h exp %h", name, d, e); end
    release_out();
  endtask

  task automatic test_len_zero();
    logic [31:0] d, e;
    bit to;
    // A term offered outside ACC must never be consumed.
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    exp_q.push_back(32'h0);
    do_start(0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %b exp 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len0_in_ready got %b exp 0", in_ready); end
    e = exp_q.pop_front();
    checks++; if (out_data !== e) begin errors++; $display("FAIL len0_data got %h exp %h", out_data, e); end
    release_out();
    tick();
    in_valid = 1'b0;
    exp_q.push_back(relu_exp(32'h4000_0000));
    do_start(1);
    send_term(32'h4000_0000, 0);
    collect(d, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL idle_ignore timeout"); end
    else if (d !== e) begin errors++; $display("FAIL idle_ignore got %h exp %h", d, e); end
    release_out();
  endtask

  task automatic test_hold_done();
    logic [31:0] d, e;
    bit to;
    exp_q.push_back(relu_exp(32'h4040_0000));
    do_start(1);
    send_term(32'h4040_0000, 0);
    collect(d, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL hold_first timeout"); end
    else if (d !== e) begin errors++; $display("FAIL hold_first got %h exp %h", d, e); end
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      len   = LEN_W'(2);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b exp 1", i, out_valid); end
      checks++; if (out_data !== e) begin errors++; $display("FAIL hold_data cyc %0d got %h exp %h", i, out_data, e); end
    end
    start = 1'b0;
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] d, e;
    bit to;
    do_start(4);
    send_term(32'h3F80_0000, 0);
    send_term(32'h4000_0000, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    exp_q.push_back(relu_exp(32'h3F80_0000));
    do_start(1);
    send_term(32'h3F80_0000, 0);
    collect(d, to);
    e = exp_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL midrst_newjob timeout"); end
    else if (d !== e) begin errors++; $display("FAIL midrst_newjob got %h exp %h", d, e); end
    release_out();
  endtask

  task automatic test_random_int();
    logic [31:0] d, e;
    bit to;
    int n, v, sum;
    for (int j = 0; j < 8; j++) begin
      n   = $urandom_range(8, 1);
      sum = 0;
      do_start(n);
      for (int k = 0; k < n; k++) begin
        v = int'($urandom_range(2000)) - 1000;
        sum += v;
        if (k == n - 1) exp_q.push_back(relu_exp(int_to_fp(sum)));
        send_term(int_to_fp(v), $urandom_range(2));
      end
      repeat ($urandom_range(3)) tick();
      collect(d, to);
      e = exp_q.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL rand_job%0d timeout", j); end
      else if (d !== e) begin errors++; $display("FAIL rand_job%0d got %h exp %h (int sum %0d)", j, d, e, sum); end
      release_out();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;

    test_reset();
    test_sum_basic();
    test_pair("cancel", 32'h4020_0000, 32'hC020_0000, 32'h0000_0000);
    test_pair("align_out", 32'h4E80_0000, 32'h3F80_0000, 32'h4E80_0000);
    test_pair("negative", 32'hBF80_0000, 32'hC000_0000, 32'hC040_0000);
    test_pair("saturate", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
    test_pair("neg_saturate", 32'hFF7F_FFFF, 32'hFF00_0000, 32'hFF7F_FFFF);
    test_pair("underflow_flush", 32'h00C0_0000, 32'h8080_0000, 32'h0000_0000);
    test_pair("zero_exp_pass", 32'h0012_3456, 32'hC0A0_0000, 32'hC0A0_0000);
    test_pair("unequal_sub", 32'h4120_0000, 32'hBF80_0000, 32'h4110_0000);
    test_len_zero();
    test_hold_done();
    test_reset_mid_job();
    test_random_int();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
